reg_scoreboard: RTL

Parametrised in-order register scoreboard for the five-stage core: records every destination register write issued from decode into execute, holds it until writeback retires it, and stalls decode on read-after-write (optionally write-after-write) hazards. It replaces the fixed three-stage waddr comparison with a depth- and port-count-generic tracker. It sits between id_stage (issue side) and wb_stage (retire side), beside regfile.

---
 rtl/reg_scoreboard_pkg.sv | 17 +
 rtl/reg_scoreboard_sb_fifo.sv | 48 ++++
 rtl/reg_scoreboard.sv | 102 ++++++++++
 3 files changed

// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared core constants and issue-bus layout for the register scoreboard
package reg_scoreboard_pkg;

  localparam int SB_NREG    = 32;
  localparam int SB_AW      = 5;
  localparam int SB_NRD     = 2;
  localparam int SB_DEPTH   = 4;
  localparam int SB_MAXPEND = 3;

  typedef struct packed {
    logic                     we;
    logic [SB_AW-1:0]         waddr;
    logic [SB_NRD-1:0]        rden;
    logic [SB_NRD*SB_AW-1:0]  raddr;
  } sb_issue_t;

endpackage

// File: rtl/reg_scoreboard_sb_fifo.sv
// rtl/reg_scoreboard_sb_fifo.sv - DEPTH x AW synchronous FIFO of in-flight destination registers
module sb_fifo
  import reg_scoreboard_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [AW-1:0]              push_data,
  input  logic                       pop,
  output logic [AW-1:0]              head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Storage needs no reset: head is only meaningful while count != 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - in-order register scoreboard stalling decode on RAW (and WAW with SB_WAW_CHECK_EN)
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG    = SB_NREG,
  parameter int AW      = SB_AW,
  parameter int NRD     = SB_NRD,
  parameter int DEPTH   = SB_DEPTH,
  parameter int MAXPEND = SB_MAXPEND
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       iss_valid,
  output logic                       iss_ready,
  input  logic                       iss_we,
  input  logic [AW-1:0]              iss_waddr,
  input  logic [NRD-1:0]             iss_rden,
  input  logic [NRD*AW-1:0]          iss_raddr,
  input  logic                       ret_valid,
  output logic [AW-1:0]              ret_waddr,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] pend_cnt,
  output logic                       err
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PCW = $clog2(MAXPEND + 1);

  logic [PCW-1:0]  cnt [NREG];
  logic [AW-1:0]   head;
  logic [CW-1:0]   count;
  logic            tracked;
  logic            raw;
  logic            cap;
  logic            waw;
  logic            fire;
  logic            pop;
  logic [NREG-1:0] inc;
  logic [NREG-1:0] dec;

  assign tracked = iss_we && (iss_waddr != '0);

  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      if (iss_rden[i] && (iss_raddr[i*AW +: AW] != '0) && (cnt[iss_raddr[i*AW +: AW]] != '0))
        raw = 1'b1;
    end
  end

  // Capacity is judged on pre-edge state, so a same-cycle retire never frees a slot.
  assign cap = tracked && ((count == CW'(DEPTH)) || (cnt[iss_waddr] == PCW'(MAXPEND)));

`ifdef SB_WAW_CHECK_EN
  assign waw = tracked && (cnt[iss_waddr] != '0);
`else
  assign waw = 1'b0;
`endif

  assign iss_ready = !(raw || cap || waw);
  assign fire      = iss_valid && iss_ready && tracked;
  assign pop       = ret_valid && (count != '0);

  sb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fire),
    .push_data (iss_waddr),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    inc = '0;
    dec = '0;
    if (fire) inc[iss_waddr] = 1'b1;
    if (pop)  dec[head]      = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      err <= 1'b0;
    end else begin
      if (ret_valid && (count == '0)) err <= 1'b1;
      // Issue and retire to the same register cancel out.
      for (int r = 0; r < NREG; r++) begin
        if (inc[r] && !dec[r])      cnt[r] <= cnt[r] + 1'b1;
        else if (dec[r] && !inc[r]) cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  assign ret_waddr = (count != '0) ? head : '0;
  assign busy      = (count != '0);
  assign pend_cnt  = count;

endmodule
